// File: rtl/tcdm_l2_responder.sv
// tcdm_l2_responder: XBAR_TCDM slave serving one L2 SRAM bank with fixed read latency and optional wait states
module tcdm_l2_responder #(
    parameter int unsigned RDATA_WIDTH    = 32,
    parameter logic [31:0] BASE_ADDR      = 32'h1C00_0000,
    parameter logic [31:0] SIZE_BYTES     = 32'h0008_0000,
    parameter int unsigned WAIT_CYCLES    = 0,
    parameter int unsigned MEM_ADDR_WIDTH = 17
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    input  logic [31:0]               add_i,
    input  logic                      wen_i,
    input  logic [31:0]               wdata_i,
    input  logic [3:0]                be_i,
    output logic                      gnt_o,
    output logic                      r_valid_o,
    output logic [RDATA_WIDTH-1:0]    r_rdata_o,
    output logic                      r_opc_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [RDATA_WIDTH/8-1:0]  mem_be_o,
    output logic [RDATA_WIDTH-1:0]    mem_wdata_o,
    input  logic [RDATA_WIDTH-1:0]    mem_rdata_i
);
    localparam int unsigned BW    = RDATA_WIDTH / 8;
    localparam int unsigned OFFB  = $clog2(BW);
    localparam int unsigned LANES = RDATA_WIDTH / 32;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      r_state, w_next;
    logic [3:0]  r_cnt, w_cnt;
    logic [31:0] r_add, r_wdata;
    logic        r_wen;
    logic [3:0]  r_be;
    logic        w_accept, w_access, w_resp, w_a_wen, w_a_in, w_r_in;
    logic [31:0] w_a_add, w_a_wdata;
    logic [3:0]  w_a_be;
    logic [32:0] w_off;
    logic [1:0]  w_lane;

    function automatic logic in_range(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) && (({1'b0, a} - {1'b0, BASE_ADDR}) < {1'b0, SIZE_BYTES});
    endfunction

    always_comb begin
        w_accept  = rst_ni && req_i && (r_state == IDLE || r_state == RESP);
        w_access  = rst_ni && ((WAIT_CYCLES == 0) ? w_accept : (r_state == WAIT && r_cnt == 4'd0));
        w_a_add   = (WAIT_CYCLES == 0) ? add_i : r_add;
        w_a_wen   = (WAIT_CYCLES == 0) ? wen_i : r_wen;
        w_a_wdata = (WAIT_CYCLES == 0) ? wdata_i : r_wdata;
        w_a_be    = (WAIT_CYCLES == 0) ? be_i : r_be;
        w_a_in    = in_range(w_a_add);
        w_off     = {1'b0, w_a_add} - {1'b0, BASE_ADDR};
        w_lane    = w_off[3:2] & 2'(LANES - 1);
        w_resp    = rst_ni && r_state == RESP;
        w_r_in    = in_range(r_add);
        w_next    = (r_state == WAIT) ? ((r_cnt == 4'd0) ? RESP : WAIT)
                  : w_accept ? ((WAIT_CYCLES == 0) ? RESP : WAIT) : IDLE;
        w_cnt     = (r_state == WAIT) ? r_cnt - 4'd1 : 4'(WAIT_CYCLES - 1);
    end

    assign gnt_o       = w_accept;
    assign mem_req_o   = w_access && w_a_in;
    assign mem_we_o    = mem_req_o && !w_a_wen;
    assign mem_addr_o  = MEM_ADDR_WIDTH'(w_off >> OFFB);
    assign mem_be_o    = w_a_wen ? {BW{1'b1}} : (BW'(w_a_be) << {w_lane, 2'b00});
    assign mem_wdata_o = {LANES{w_a_wdata}};
    assign r_valid_o   = w_resp;
    assign r_opc_o     = w_resp && !w_r_in;
    // SRAM data is only meaningful for in-range reads; everything else returns zero
    assign r_rdata_o   = (w_resp && w_r_in && r_wen) ? mem_rdata_i : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_add   <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            if (w_accept) begin
                r_add   <= add_i;
                r_wen   <= wen_i;
                r_wdata <= wdata_i;
                r_be    <= be_i;
            end
        end
    end
endmodule
